// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store funct3
// codes, the access FSM states and the alignment/legality helpers.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic load_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data memory (slave).
interface data_mem_responder_if;

  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_busywait;
  logic        mem_error;

  modport master (
    output mem_read, mem_write, mem_func3, mem_address, mem_write_data,
    input  mem_read_data, mem_busywait, mem_error
  );

  modport slave (
    input  mem_read, mem_write, mem_func3, mem_address, mem_write_data,
    output mem_read_data, mem_busywait, mem_error
  );

endinterface

// File: rtl/data_mem_responder_store_lane_merge.sv
// Combinational byte-lane merge of SB/SH/SW store data into an existing word,
// flagging misaligned half/word stores. Illegal funct3 leaves the word untouched.
module store_lane_merge
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] old_word,
  output logic [31:0] merged_word,
  output logic        misalign
);

  // Lane select by store width and byte offset.
  always_comb begin
    merged_word = old_word;
    misalign    = access_misaligned(funct3, offset);
    case (funct3)
      F3_B:    merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      F3_H:    merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      F3_W:    merged_word = store_data;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed-latency stall,
// byte-lane stores and right-aligned load data.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [ADDR_W+1:0]    addr_r;
  logic [2:0]           f3_r;
  logic [31:0]          wdata_r;
  logic                 rd_r, wr_r;
  logic [31:0]          read_data_r;
  logic                 error_r;
  logic                 busy_s;
  logic                 req_s;
  logic                 fire_s;
  logic                 err_s;
  logic [31:0]          mem_word_s;
  logic [31:0]          merged_s;
  logic                 st_misalign_s;
  logic [ADDR_W-1:0]    idx_s;
  logic                 unused_addr_s;

  logic [31:0] mem [DEPTH];

  assign req_s         = bus.mem_read | bus.mem_write;
  assign fire_s        = (state_r == ACCESS) && (cnt_r == '0);
  assign idx_s         = addr_r[ADDR_W+1:2];
  assign mem_word_s    = mem[idx_s];
  assign unused_addr_s = ^bus.mem_address[31:ADDR_W+2];

  store_lane_merge u_merge (
    .funct3      (f3_r),
    .offset      (addr_r[1:0]),
    .store_data  (wdata_r),
    .old_word    (mem_word_s),
    .merged_word (merged_s),
    .misalign    (st_misalign_s)
  );

  // Error classification on the latched request.
  always_comb begin
    err_s = 1'b0;
    if (rd_r && wr_r) begin
      err_s = 1'b1;
    end else if (wr_r) begin
      err_s = !store_f3_legal(f3_r) || st_misalign_s;
    end else if (rd_r) begin
      err_s = !load_f3_legal(f3_r) || access_misaligned(f3_r, addr_r[1:0]);
    end else begin
      err_s = 1'b0;
    end
  end

  // Next-state and stall decode.
  always_comb begin
    state_s = state_r;
    busy_s  = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = req_s;
        if (req_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        busy_s = 1'b1;
        if (cnt_r == '0) begin
          state_s = DONE;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      addr_r  <= '0;
      f3_r    <= 3'b000;
      wdata_r <= 32'h0000_0000;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else if ((state_r == IDLE) && req_s) begin
      cnt_r   <= CNT_W'(LATENCY - 1);
      addr_r  <= bus.mem_address[ADDR_W+1:0];
      f3_r    <= bus.mem_func3;
      wdata_r <= bus.mem_write_data;
      rd_r    <= bus.mem_read;
      wr_r    <= bus.mem_write;
    end else if ((state_r == ACCESS) && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Load data and error pulse; read data holds across stores and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_r <= 32'h0000_0000;
      error_r     <= 1'b0;
    end else if (fire_s) begin
      if (err_s) begin
        read_data_r <= 32'h0000_0000;
        error_r     <= 1'b1;
      end else if (rd_r) begin
        read_data_r <= mem_word_s >> {addr_r[1:0], 3'b000};
        error_r     <= 1'b0;
      end else begin
        error_r     <= 1'b0;
      end
    end else begin
      error_r <= 1'b0;
    end
  end

  // Memory array is deliberately not reset; an async reset drops state_r out
  // of ACCESS before the firing edge, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (fire_s && wr_r && !err_s) begin
      mem[idx_s] <= merged_s;
    end
  end

  assign bus.mem_read_data = read_data_r;
  assign bus.mem_error     = error_r;
  assign bus.mem_busywait  = busy_s;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage load/store interface.
- Accepts one read or write request at a time from the MEM stage and stalls the pipeline via MEM_BUSYWAIT for a fixed access latency.
- Stores: merges SB/SH/SW data into the addressed word using byte lanes.
- Loads: returns the addressed word right-aligned by byte offset. Sign and zero extension stay in the WB load processing unit.

Parameters:
- ADDR_W, 10: word-address width; DEPTH = 2**ADDR_W 32-bit words.
- LATENCY, 2: access cycles after acceptance (>=1); total stall = LATENCY+1 cycles.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- MEM_READ  in  1  load request, held by MEM stage until MEM_BUSYWAIT falls.
- MEM_WRITE  in  1  store request, held likewise.
- MEM_FUNC3  in  3  RV32 load/store funct3.
- MEM_ADDRESS  in  32  byte address.
- MEM_WRITE_DATA  in  32  store data, right-aligned (rs2).
- MEM_READ_DATA  out  32  loaded word shifted right by 8*MEM_ADDRESS[1:0].
- MEM_BUSYWAIT  out  1  stall request to pipeline.
- MEM_ERROR  out  1  one-cycle pulse on misaligned or illegal access.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, counter 0, MEM_READ_DATA 0, MEM_ERROR 0. MEM_BUSYWAIT 0 because it decodes to 0 in IDLE with no request.
- Reset does not clear the memory array.
- Reset during ACCESS aborts the request; no partial write occurs.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - MEM_BUSYWAIT = MEM_READ | MEM_WRITE, combinational, in the same cycle.
  - On request, latch address, func3, data and op; counter <= LATENCY-1; go to ACCESS.
- ACCESS:
  - MEM_BUSYWAIT = 1.
  - While counter != 0, decrement.
  - At counter == 0, perform the access at the clock edge; go to DONE.
- DONE:
  - MEM_BUSYWAIT = 0; MEM_READ_DATA valid; MEM_ERROR valid (one cycle).
  - Request inputs are ignored, since they still show the completed request.
  - Next state is IDLE.
- Back-to-back requests: a new request is sampled only in IDLE, so consecutive accesses are separated by the DONE cycle.
- Word index = latched address[ADDR_W+1:2]; higher address bits are ignored (wrap-around).
- Store lane rules:
  - SB (000): byte lane addr[1:0] <= data[7:0].
  - SH (001): lanes {addr[1],0} and {addr[1],1} <= data[15:0].
  - SW (010): whole word.
- Load: funct3 000/001/010/100/101 read the word; MEM_READ_DATA <= word >> (8*addr[1:0]). Upper bits are left as-is for the WB extender.
- Errors (MEM_ERROR = 1 in DONE, no write, MEM_READ_DATA <= 0):
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - store funct3 not in {000, 001, 010};
  - load funct3 in {011, 110, 111};
  - MEM_READ and MEM_WRITE both high.
- MEM_READ_DATA holds its value after DONE until the next completed read or error.
- MEM_READ_DATA is unchanged by a completed store.

Decomposition:
- Shared package: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum (IDLE, ACCESS, DONE).
- Sub-module store_lane_merge (combinational): inputs funct3, addr[1:0], store data, old word; outputs merged word and misalign flag. It is reused by any future cache.

Test Plan:
- Reset then SW addr 0x00000010 data 0xDEADBEEF, LATENCY = 2 -> MEM_BUSYWAIT high 3 cycles, then low 1 cycle, MEM_ERROR 0.
- LW addr 0x10 after that SW -> MEM_READ_DATA = 0xDEADBEEF in DONE.
- SB addr 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF.
- SH addr 0x12 data 0x1234, then LW 0x10 -> 0x1234AAEF.
- LB addr 0x13 -> MEM_READ_DATA = 0x00000012 (word >> 24).
- LW addr 0x12 -> MEM_ERROR pulses 1 cycle, MEM_READ_DATA = 0, memory unchanged.
- SW 0x20 data 0xCAFEBABE with RST pulsed low during ACCESS -> outputs return to reset values immediately; a following LW 0x20 returns the prior contents, not 0xCAFEBABE.
- Simultaneous MEM_READ = MEM_WRITE = 1 -> MEM_ERROR pulse, no write.
